// File: rtl/circuit_ii_dash.sv
// Two cascaded 16-bit ALU slices feeding a single result register, with zero and negative flags.
// Latency: 1 clock from the operands and controls to out; zr and ng are decoded from out, so they add no latency.
// No backpressure: every input is consumed on every rising edge, and there is no enable or hold.
module circuit_ii_dash (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f0,
    input  logic        f1,
    input  logic        no,
    input  logic [15:0] y_dash,
    input  logic        zx_d,
    input  logic        nx_d,
    input  logic        zy_d,
    input  logic        ny_d,
    input  logic        f0_d,
    input  logic        f1_d,
    input  logic        no_d
);

    // One ALU slice. The zero/negate steps act on a, then on b. Then the op is selected.
    // The result can then be inverted. The add wraps modulo 2^16 because the carry has nowhere to go.
    function automatic logic [15:0] alu_slice(
        input logic [15:0] a_in,
        input logic [15:0] b_in,
        input logic        c_zx,
        input logic        c_nx,
        input logic        c_zy,
        input logic        c_ny,
        input logic        c_f0,
        input logic        c_f1,
        input logic        c_no
    );
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        a = c_zx ? 16'h0000 : a_in;
        a = c_nx ? ~a : a;
        b = c_zy ? 16'h0000 : b_in;
        b = c_ny ? ~b : b;
        case ({c_f0, c_f1})
            2'b00:   r = a & b;
            2'b10:   r = a + b;
            2'b01:   r = a | b;
            default: r = a ^ b;
        endcase
        return c_no ? ~r : r;
    endfunction

    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] out_d;
    logic [15:0] out_q;

    // Both slices sit in one combinational path. Stage 1 drives the a input of stage 2 directly.
    always_comb begin
        s1    = alu_slice(x, y, zx, nx, zy, ny, f0, f1, no);
        s2    = alu_slice(s1, y_dash, zx_d, nx_d, zy_d, ny_d, f0_d, f1_d, no_d);
        out_d = s2;
    end

    // The result register. Reset wins over the load, so a pending s2 is dropped while reset is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= 16'h0000;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
    assign zr  = (out_q == 16'h0000);
    assign ng  = out_q[15];

endmodule

// File: tb/tb_circuit_ii_dash.sv
// Directed bench for circuit_ii_dash.
// Stimulus changes on the falling edge. Results are sampled 1 time unit after the rising edge.
// Expected values are worked out by hand from the ALU definition.
module tb_circuit_ii_dash;

    logic        clk;
    logic        reset;
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] y_dash;
    logic [6:0]  c1;   // {zx,nx,zy,ny,f0,f1,no}
    logic [6:0]  c2;   // {zx_d,nx_d,zy_d,ny_d,f0_d,f1_d,no_d}

    int tests;
    int fails;

    circuit_ii_dash dut (
        .clk    (clk),
        .reset  (reset),
        .out    (out),
        .zr     (zr),
        .ng     (ng),
        .x      (x),
        .y      (y),
        .zx     (c1[6]),
        .nx     (c1[5]),
        .zy     (c1[4]),
        .ny     (c1[3]),
        .f0     (c1[2]),
        .f1     (c1[1]),
        .no     (c1[0]),
        .y_dash (y_dash),
        .zx_d   (c2[6]),
        .nx_d   (c2[5]),
        .zy_d   (c2[4]),
        .ny_d   (c2[3]),
        .f0_d   (c2[2]),
        .f1_d   (c2[1]),
        .no_d   (c2[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one vector on the falling edge, then advance past the next rising edge.
    task automatic step(input logic rst, input logic [15:0] xv, input logic [15:0] yv,
                        input logic [15:0] ydv, input logic [6:0] c1v, input logic [6:0] c2v);
        @(negedge clk);
        reset  = rst;
        x      = xv;
        y      = yv;
        y_dash = ydv;
        c1     = c1v;
        c2     = c2v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b0;
        x      = 16'd0;
        y      = 16'd0;
        y_dash = 16'd0;
        c1     = 7'b0;
        c2     = 7'b0;

        // Reset for one edge.
        step(1'b1, 16'd1023, 16'd2047, 16'd1234, 7'b0000100, 7'b0000100);
        chk16("reset_out", out, 16'd0);
        chk1 ("reset_zr",  zr,  1'b1);
        chk1 ("reset_ng",  ng,  1'b0);

        // add/add: 1023+2047=3070, then 3070+1234=4304.
        step(1'b0, 16'd1023, 16'd2047, 16'd1234, 7'b0000100, 7'b0000100);
        chk16("addadd_out", out, 16'd4304);
        chk1 ("addadd_zr",  zr,  1'b0);
        chk1 ("addadd_ng",  ng,  1'b0);

        // and/xor: 1023 & 0xFFFF = 1023, then 1023 ^ 1234 = 1837.
        step(1'b0, 16'd1023, 16'd2047, 16'd1234, 7'b0011000, 7'b0000110);
        chk16("andxor_out", out, 16'd1837);

        // add/xor: 3070 ^ 1234 = 3884.
        step(1'b0, 16'd1023, 16'd2047, 16'd1234, 7'b0000100, 7'b0000110);
        chk16("addxor_out", out, 16'd3884);

        // Both operands zeroed in stage 1, y_dash zeroed in stage 2: the result is 0.
        step(1'b0, 16'd1023, 16'd2047, 16'd1234, 7'b1010100, 7'b0010100);
        chk16("zero_out", out, 16'd0);
        chk1 ("zero_zr",  zr,  1'b1);
        chk1 ("zero_ng",  ng,  1'b0);

        // Output negate: ~3070 = -3071 = 0xF401.
        step(1'b0, 16'd1023, 16'd2047, 16'd1234, 7'b0000100, 7'b0010101);
        chk16("neg_out", out, 16'hF401);
        chk1 ("neg_ng",  ng,  1'b1);
        chk1 ("neg_zr",  zr,  1'b0);

        // Wrap: 32767+1 = -32768 = 0x8000.
        step(1'b0, 16'd32767, 16'd1, 16'd1234, 7'b0000100, 7'b0010100);
        chk16("wrap_out", out, 16'h8000);
        chk1 ("wrap_ng",  ng,  1'b1);

        // OR and nx: 0x00F0 | 0x0F00 = 0x0FF0. Then ~0x0FF0 | 0 = 0xF00F.
        step(1'b0, 16'h00F0, 16'h0F00, 16'h1234, 7'b0000010, 7'b0110010);
        chk16("or_nx_out", out, 16'hF00F);

        // AND with ny in stage 2: 0x00F0 & ~0x0F0F = 0x00F0 & 0xF0F0 = 0x00F0.
        step(1'b0, 16'h00F0, 16'h0000, 16'h0F0F, 7'b0001000, 7'b0001000);
        chk16("and_ny_out", out, 16'h00F0);

        // Reset takes priority over valid add/add data.
        step(1'b1, 16'd1023, 16'd2047, 16'd1234, 7'b0000100, 7'b0000100);
        chk16("rstprio_out", out, 16'd0);
        chk1 ("rstprio_zr",  zr,  1'b1);

        // Loading resumes on the first edge with reset low.
        step(1'b0, 16'd1023, 16'd2047, 16'd1234, 7'b0000100, 7'b0000100);
        chk16("resume_out", out, 16'd4304);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stalled simulation.
    initial begin
        #100000;
        $display("FAIL timeout observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/circuit_ii_dash.md
CIRCUIT_II_DASH -- requirements
Module: circuit_ii_dash

Interface
REQ-001: clk  input  1  — single clock; all state updates on rising edge.
REQ-002: reset  input  1  — synchronous, active-high; sampled on rising clk edge.
REQ-003: out  output  16  — signed result register, two's complement.
REQ-004: zr  output  1  — high when out == 0.
REQ-005: ng  output  1  — high when out[15] == 1 (out negative).
REQ-006: x  input  16  — signed operand X of stage 1.
REQ-007: y  input  16  — signed operand Y of stage 1.
REQ-008: zx, nx, zy, ny, f0, f1, no  input  1 each  — stage-1 controls, listed in port order.
REQ-009: y_dash  input  16  — signed operand Y of stage 2.
REQ-010: zx_d, nx_d, zy_d, ny_d, f0_d, f1_d, no_d  input  1 each  — stage-2 controls, listed in port order.
REQ-011: Port order SHALL be clk, reset, out, zr, ng, x, y, stage-1 controls, y_dash, stage-2 controls.

Function
REQ-012: Each stage SHALL be a combinational 16-bit ALU slice A(a, b, ctrl) applying these steps in order:
- zx: a := 0
- nx: a := ~a
- zy: b := 0
- ny: b := ~b
- op select
- no: r := ~r
REQ-013: Op select by {f0,f1}:
- 00 → a & b
- 10 → a + b
- 01 → a | b
- 11 → a ^ b
REQ-014: Addition SHALL be modulo 2^16 (carry out discarded, no overflow flag).
REQ-015: Stage-1 result s1 = A(x, y, stage-1 controls).
REQ-016: Stage-2 result s2 = A(s1, y_dash, stage-2 controls), so stage 1 feeds stage 2's a input directly.
REQ-017: On each rising clk edge with reset low, out SHALL load s2; latency = 1 clock from input change to out.
REQ-018: zr and ng SHALL be combinational decodes of the registered out (no extra latency); both SHALL update in the same cycle as out.
REQ-019: No internal pipelining between stages; both stages SHALL evaluate within one clock period.
REQ-020: All inputs SHALL be treated as fully independent each cycle; no enable and no hold.

Reset
REQ-021: With reset high at a rising edge, out SHALL become 0, giving zr=1, ng=0; reset SHALL take priority over loading s2.
REQ-022: Reset asserted mid-operation SHALL discard the pending s2; normal loading SHALL resume on the first edge with reset low.
REQ-023: Before the first reset, out is undefined; the bench SHALL reset before checking.

Verification
REQ-024 (reset): reset=1 for one edge → out=0, zr=1, ng=0.
REQ-025 (add/add): x=1023, y=1023+1024=2047, y_dash=1234, stage-1 controls 0000100, stage-2 controls 0000100 → after one edge out=4304, zr=0, ng=0.
REQ-026 (and/xor): same data, stage-1 controls 0011000 (y forced to -1, AND → 1023), stage-2 controls 0000110 (XOR) → out=1837.
REQ-027 (add/xor): same data, stage-1 controls 0000100 (3070), stage-2 controls 0000110 → out=3884.
REQ-028 (zero, negate, wrap):
- stage-1 controls 1010100 (0+0), stage-2 controls 0010100 → out=0, zr=1.
- stage-1 controls 0000100, stage-2 controls 0010101 (~3070) → out=-3071, ng=1.
- x=32767, y=1, stage-1 controls 0000100, stage-2 controls 0010100 → out=-32768, ng=1.
REQ-029 (reset priority): reset=1 together with the REQ-025 data → out=0; deassert reset → next edge out=4304.
